operand_fetch: RTL and testbench

//  Operand-fetch stage between decode and execute. Accepts one decoded instr per

---
 rtl/operand_fetch.sv | 158 +++++++++++++++
 tb/tb_operand_fetch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand-fetch stage: drives the sync RF read ports, captures 1-cycle read data,
// and bypasses writebacks that collide with the read or land while operands stall.
module operand_fetch_src #(
    parameter int XLEN  = 32,
    parameter int depth = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             accept_i,
    input  logic             fresh_i,
    input  logic             busy_i,
    input  logic [depth-1:0] in_addr_i,
    input  logic             wb_we_i,
    input  logic [depth-1:0] wb_addr_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic [XLEN-1:0]  rf_data_i,
    output logic [depth-1:0] rf_addr_o,
    output logic [depth-1:0] addr_o,
    output logic [XLEN-1:0]  data_o
);
    logic [depth-1:0] addr_q;
    logic             cap_q;
    logic [XLEN-1:0]  capd_q;
    logic [XLEN-1:0]  hold_q;
    logic [XLEN-1:0]  base;

    // A write on the accept edge is missed by the sync read, so grab it here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cap_q  <= 1'b0;
            capd_q <= '0;
            hold_q <= '0;
        end else begin
            if (accept_i) begin
                addr_q <= in_addr_i;
                cap_q  <= wb_we_i && (wb_addr_i == in_addr_i) && (wb_addr_i != '0);
                capd_q <= wb_data_i;
            end
            if (busy_i)
                hold_q <= data_o;
        end
    end

    always_comb begin
        base = hold_q;
        if (fresh_i)
            base = cap_q ? capd_q : rf_data_i;
        data_o = base;
        if (addr_q == '0)
            data_o = '0;
        else if (wb_we_i && (wb_addr_i == addr_q))
            data_o = wb_data_i;
    end

    assign rf_addr_o = accept_i ? in_addr_i : addr_q;
    assign addr_o    = addr_q;
endmodule

module operand_fetch #(
    parameter int XLEN  = 32,
    parameter int depth = 5,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [depth-1:0] in_rs1_addr,
    input  logic [depth-1:0] in_rs2_addr,
    input  logic [TAG_W-1:0] in_tag,
    output logic [depth-1:0] rf_rs1_addr,
    output logic [depth-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic             wb_we,
    input  logic [depth-1:0] wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [depth-1:0] out_rs1_addr,
    output logic [depth-1:0] out_rs2_addr,
    output logic [XLEN-1:0]  out_rs1_data,
    output logic [XLEN-1:0]  out_rs2_data,
    output logic [TAG_W-1:0] out_tag
);
    localparam int NSRC = 2;

    typedef enum logic [1:0] {EMPTY = 2'd0, FRESH = 2'd1, HELD = 2'd2} state_t;

    state_t                       state_q, state_d;
    logic                         accept;
    logic [TAG_W-1:0]             tag_q;
    logic [NSRC-1:0][depth-1:0]   src_in_addr, src_rf_addr, src_out_addr;
    logic [NSRC-1:0][XLEN-1:0]    src_rf_data, src_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = EMPTY;
        else if (accept)
            state_d = FRESH;
        else if (state_q != EMPTY && out_ready)
            state_d = EMPTY;
        else if (state_q != EMPTY)
            state_d = HELD;
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = !flush && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tag_q <= '0;
        else if (accept)
            tag_q <= in_tag;
    end

    assign src_in_addr = {in_rs2_addr, in_rs1_addr};
    assign src_rf_data = {rf_rs2_data, rf_rs1_data};

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        operand_fetch_src #(.XLEN(XLEN), .depth(depth)) u_src (
            .clk       (clk),
            .rst_n     (rst_n),
            .accept_i  (accept),
            .fresh_i   (state_q == FRESH),
            .busy_i    (state_q != EMPTY),
            .in_addr_i (src_in_addr[g]),
            .wb_we_i   (wb_we),
            .wb_addr_i (wb_addr),
            .wb_data_i (wb_data),
            .rf_data_i (src_rf_data[g]),
            .rf_addr_o (src_rf_addr[g]),
            .addr_o    (src_out_addr[g]),
            .data_o    (src_out_data[g])
        );
    end

    assign rf_rs1_addr  = src_rf_addr[0];
    assign rf_rs2_addr  = src_rf_addr[1];
    assign out_rs1_addr = src_out_addr[0];
    assign out_rs2_addr = src_out_addr[1];
    assign out_rs1_data = src_out_data[0];
    assign out_rs2_data = src_out_data[1];
    assign out_tag      = tag_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural sync-read register file.
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, rf_rs1_addr, rf_rs2_addr, wb_addr;
    logic [4:0]  out_rs1_addr, out_rs2_addr;
    logic [31:0] in_tag, rf_rs1_data, rf_rs2_data, wb_data;
    logic [31:0] out_rs1_data, out_rs2_data, out_tag;
    logic        wb_we, out_valid, out_ready;
    logic        preload;
    logic [31:0] mem [32];

    int errors = 0;
    int checks = 0;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_tag(in_tag),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Sync RF: read returns the pre-write contents when read and write share an edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + i;
            mem[0] <= 32'h0;
            mem[5] <= 32'h11;
            mem[7] <= 32'h01;
            mem[9] <= 32'h33;
            rf_rs1_data <= '0;
            rf_rs2_data <= '0;
        end else begin
            rf_rs1_data <= mem[rf_rs1_addr];
            rf_rs2_data <= mem[rf_rs2_addr];
            if (wb_we) mem[wb_addr] <= wb_data;
        end
    end

    typedef struct {
        logic        iv;
        logic [4:0]  rs1, rs2;
        logic [31:0] tag;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ordy, fl;
        logic        e_ir, e_ov, cd;
        logic [4:0]  e_a1, e_a2;
        logic [31:0] e_d1, e_d2, e_tag;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic iv, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] tag,
                                logic we, logic [4:0] wa, logic [31:0] wd, logic ordy, logic fl,
                                logic e_ir, logic e_ov, logic cd, logic [4:0] e_a1, logic [4:0] e_a2,
                                logic [31:0] e_d1, logic [31:0] e_d2, logic [31:0] e_tag);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.tag = tag;
        v.we = we; v.wa = wa; v.wd = wd; v.ordy = ordy; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.cd = cd; v.e_a1 = e_a1; v.e_a2 = e_a2;
        v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_tag = e_tag;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] tag, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ordy, input logic fl);
        in_valid = iv; in_rs1_addr = rs1; in_rs2_addr = rs2; in_tag = tag;
        wb_we = we; wb_addr = wa; wb_data = wd; out_ready = ordy; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int run;
        rst_n = 1'b0;
        preload = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        //            iv rs1 rs2 tag      we wa wd      ordy fl  eir eov cd a1 a2 d1      d2      tag
        tbl[0]  = mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0,  1, 0, 1, 0, 0, 32'h0,  32'h0,  32'h0);
        tbl[1]  = mk(1, 5, 0, 32'hA1, 0, 0, 32'h0,  1, 0,  1, 0, 0, 0, 0, 32'h0,  32'h0,  32'h0);
        tbl[2]  = mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0,  1, 1, 1, 5, 0, 32'h11, 32'h0,  32'hA1);
        tbl[3]  = mk(1, 7, 5, 32'hA2, 1, 7, 32'hAB, 1, 0,  1, 0, 0, 0, 0, 32'h0,  32'h0,  32'h0);
        tbl[4]  = mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0,  1, 1, 1, 7, 5, 32'hAB, 32'h11, 32'hA2);
        tbl[5]  = mk(1, 5, 9, 32'hA3, 0, 0, 32'h0,  0, 0,  1, 0, 0, 0, 0, 32'h0,  32'h0,  32'h0);
        tbl[6]  = mk(1, 1, 2, 32'hB0, 0, 0, 32'h0,  0, 0,  0, 1, 1, 5, 9, 32'h11, 32'h33, 32'hA3);
        tbl[7]  = mk(1, 1, 2, 32'hB0, 1, 9, 32'h55, 0, 0,  0, 1, 1, 5, 9, 32'h11, 32'h55, 32'hA3);
        tbl[8]  = mk(1, 1, 2, 32'hB0, 0, 0, 32'h0,  0, 0,  0, 1, 1, 5, 9, 32'h11, 32'h55, 32'hA3);
        tbl[9]  = mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0,  0, 1, 1, 5, 9, 32'h11, 32'h55, 32'hA3);
        tbl[10] = mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0,  1, 1, 1, 5, 9, 32'h11, 32'h55, 32'hA3);
        tbl[11] = mk(1, 0, 5, 32'hA5, 1, 0, 32'hFF, 0, 0,  1, 0, 0, 0, 0, 32'h0,  32'h0,  32'h0);
        tbl[12] = mk(0, 0, 0, 32'h0,  1, 0, 32'hFF, 0, 0,  0, 1, 1, 0, 5, 32'h0,  32'h11, 32'hA5);
        tbl[13] = mk(0, 0, 0, 32'h0,  1, 0, 32'hFF, 0, 0,  0, 1, 1, 0, 5, 32'h0,  32'h11, 32'hA5);
        tbl[14] = mk(0, 0, 0, 32'h0,  1, 0, 32'hFF, 1, 0,  1, 1, 1, 0, 5, 32'h0,  32'h11, 32'hA5);
        tbl[15] = mk(0, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0,  1, 0, 0, 0, 0, 32'h0,  32'h0,  32'h0);

        repeat (2) @(posedge clk);
        preload = 1'b0;
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].tag, tbl[i].we, tbl[i].wa,
                  tbl[i].wd, tbl[i].ordy, tbl[i].fl);
            #4;
            chk($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_ir));
            chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
            if (tbl[i].cd) begin
                chk($sformatf("row%0d rs1_addr", i), 64'(out_rs1_addr), 64'(tbl[i].e_a1));
                chk($sformatf("row%0d rs2_addr", i), 64'(out_rs2_addr), 64'(tbl[i].e_a2));
                chk($sformatf("row%0d rs1_data", i), 64'(out_rs1_data), 64'(tbl[i].e_d1));
                chk($sformatf("row%0d rs2_data", i), 64'(out_rs2_data), 64'(tbl[i].e_d2));
                chk($sformatf("row%0d tag", i), 64'(out_tag), 64'(tbl[i].e_tag));
            end
            next_cycle();
        end

        // Back-to-back stream of 8: no bubbles, tags in order.
        run = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8)
                drive(1, 5'(10 + k), 5'(20 + k), 32'hC0 + k, 0, 0, 0, 1, 0);
            else
                drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            #4;
            if (k < 8) chk($sformatf("b2b%0d in_ready", k), 64'(in_ready), 64'd1);
            if (k >= 1 && k <= 8) begin
                chk($sformatf("b2b%0d tag", k), 64'(out_tag), 64'(32'hC0 + k - 1));
                chk($sformatf("b2b%0d rs1_data", k), 64'(out_rs1_data), 64'(32'h1000 + 10 + k - 1));
                chk($sformatf("b2b%0d rs2_data", k), 64'(out_rs2_data), 64'(32'h1000 + 20 + k - 1));
            end
            if (out_valid) run++;
            next_cycle();
        end
        chk("b2b valid_run", 64'(run), 64'd8);
        chk("b2b drained", 64'(out_valid), 64'd0);

        // Flush of a held instr while decode offers another.
        drive(1, 3, 4, 32'hD0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 6, 8, 32'hD1, 0, 0, 0, 0, 1);
        #4;
        chk("flush out_valid_before", 64'(out_valid), 64'd1);
        chk("flush in_ready", 64'(in_ready), 64'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        chk("flush out_valid_after", 64'(out_valid), 64'd0);
        chk("flush tag_kept", 64'(out_tag), 64'(32'hD0));
        next_cycle();

        // Async reset mid-stall.
        drive(1, 3, 4, 32'hE0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #4;
        chk("rst stall_valid", 64'(out_valid), 64'd1);
        chk("rst stall_rs1", 64'(out_rs1_data), 64'(32'h1003));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_tag", 64'(out_tag), 64'd0);
        chk("rst out_rs1_addr", 64'(out_rs1_addr), 64'd0);
        next_cycle();
        rst_n = 1'b1;
        #4;
        chk("rst stays_empty", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
